branch_predictor: RTL and testbench

- Parametrised branch target buffer (BTB) with per-entry saturating direction counters for the pipelined RV32I core.
- Fetch stage queries it every cycle to choose the next PC, so jumps and branches no longer wait for late resolution.
- Execute stage trains it with resolved outcomes; the block flags mispredictions and supplies the redirect PC.
- Includes performance counters for lookups, hits, updates and mispredicts.

---
 rtl/branch_predictor.sv | 181 ++++++++++++++++++
 tb/tb_branch_predictor.sv | 476 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
//
// Branch target buffer with per-entry saturating direction counters for the
// pipelined RV32I core. Fetch looks it up every cycle (combinational, zero
// latency) to choose the next PC; execute trains it with resolved outcomes
// and receives a mispredict flag plus the redirect PC. Four performance
// counters track lookups, hits, updates and mispredicts.
//
// Ports
//   clk              rising-edge clock
//   reset            asynchronous, active-low reset
//   lookup_en        fetch lookup valid (affects the perf counters only)
//   lookup_pc        fetch PC
//   pred_hit         valid entry with matching tag at lookup_pc
//   pred_taken       predicted taken
//   pred_target      predicted next PC (entry target or lookup_pc + 4)
//   upd_valid        resolved control-transfer instruction this cycle
//   upd_pc           PC of the resolved instruction
//   upd_is_jump      instruction is jal/jalr
//   upd_taken        actual outcome
//   upd_target       actual taken target
//   upd_pred_taken   prediction made at fetch for this instruction
//   upd_pred_target  target predicted at fetch for this instruction
//   mispredict       redirect required
//   redirect_pc      correct next PC (meaningful only with mispredict)
//   clear            synchronous invalidate of every entry
//   cnt_lookup, cnt_hit, cnt_update, cnt_mispredict   wrapping counters
//
// Handshake: there is no back-pressure. lookup_en and upd_valid are
// single-cycle qualifiers; every cycle they are high is consumed.
// ---------------------------------------------------------------------------
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int ADDR_W  = 32,
    parameter int CTR_W   = 2,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lookup_en,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_is_jump,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_pred_taken,
    input  logic [ADDR_W-1:0] upd_pred_target,
    output logic              mispredict,
    output logic [ADDR_W-1:0] redirect_pc,
    input  logic              clear,
    output logic [CNT_W-1:0]  cnt_lookup,
    output logic [CNT_W-1:0]  cnt_hit,
    output logic [CNT_W-1:0]  cnt_update,
    output logic [CNT_W-1:0]  cnt_mispredict
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_ZERO = '0;
    // Allocation value for a conditional branch: weakly taken (MSB only).
    localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1 << (CTR_W - 1));

    // Table state, all flops so reset and clear act in a single cycle.
    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [ADDR_W-1:0] target_q [ENTRIES];
    logic              jump_q   [ENTRIES];
    logic [CTR_W-1:0]  ctr_q    [ENTRIES];

    // PC bits [1:0] are always zero for RV32I without compressed instructions.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

    // -----------------------------------------------------------------------
    // Lookup: reads the registered table only; a same-cycle update is not
    // visible until the following cycle.
    // -----------------------------------------------------------------------
    logic [IDX_W-1:0] l_idx;
    logic [TAG_W-1:0] l_tag;

    assign l_idx = lookup_pc[IDX_W+1:2];
    assign l_tag = lookup_pc[ADDR_W-1:IDX_W+2];

    always_comb begin
        pred_hit    = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
        pred_taken  = pred_hit && (jump_q[l_idx] || ctr_q[l_idx][CTR_W-1]);
        pred_target = pred_taken ? target_q[l_idx] : lookup_pc + ADDR_W'(4);
    end

    // -----------------------------------------------------------------------
    // Resolution: compare the fetch-time prediction with the real outcome.
    // -----------------------------------------------------------------------
    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             u_hit;

    assign u_idx = upd_pc[IDX_W+1:2];
    assign u_tag = upd_pc[ADDR_W-1:IDX_W+2];
    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

    always_comb begin
        mispredict  = upd_valid &&
                      ((upd_taken != upd_pred_taken) ||
                       (upd_taken && (upd_target != upd_pred_target)));
        redirect_pc = upd_taken ? upd_target : upd_pc + ADDR_W'(4);
    end

    // -----------------------------------------------------------------------
    // Training. clear has priority and discards a same-cycle update.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                jump_q[i]   <= 1'b0;
                ctr_q[i]    <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else if (upd_valid) begin
            if (u_hit) begin
                if (upd_is_jump) begin
                    ctr_q[u_idx]    <= CTR_MAX;
                    target_q[u_idx] <= upd_target;
                    jump_q[u_idx]   <= 1'b1;
                end else if (upd_taken) begin
                    if (ctr_q[u_idx] != CTR_MAX) begin
                        ctr_q[u_idx] <= ctr_q[u_idx] + CTR_W'(1);
                    end
                    target_q[u_idx] <= upd_target;
                end else if (ctr_q[u_idx] != CTR_ZERO) begin
                    ctr_q[u_idx] <= ctr_q[u_idx] - CTR_W'(1);
                end
            end else if (upd_taken) begin
                // Miss on a taken transfer: allocate, replacing any alias.
                valid_q[u_idx]  <= 1'b1;
                tag_q[u_idx]    <= u_tag;
                target_q[u_idx] <= upd_target;
                jump_q[u_idx]   <= upd_is_jump;
                ctr_q[u_idx]    <= upd_is_jump ? CTR_MAX : CTR_WEAK;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Performance counters: wrap naturally, unaffected by clear.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_lookup     <= '0;
            cnt_hit        <= '0;
            cnt_update     <= '0;
            cnt_mispredict <= '0;
        end else begin
            if (lookup_en) begin
                cnt_lookup <= cnt_lookup + CNT_W'(1);
            end
            if (lookup_en && pred_hit) begin
                cnt_hit <= cnt_hit + CNT_W'(1);
            end
            if (upd_valid) begin
                cnt_update <= cnt_update + CNT_W'(1);
            end
            if (mispredict) begin
                cnt_mispredict <= cnt_mispredict + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor
//
// Self-checking bench for branch_predictor (ENTRIES=16, CTR_W=2). A
// behavioural model of the BTB (plain arrays indexed by arithmetic on the
// PC) predicts every output; directed scenario tasks follow the test plan,
// then a randomized run compares every cycle through an expected queue.
// ---------------------------------------------------------------------------
module tb_branch_predictor;

    localparam int AW = 32;
    localparam int CW = 32;
    localparam int N  = 16;
    localparam int PW = 1 + 1 + AW + 1 + AW;   // hit, taken, target, mis, redirect

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic          lookup_en;
    logic [AW-1:0] lookup_pc;
    logic          pred_hit;
    logic          pred_taken;
    logic [AW-1:0] pred_target;
    logic          upd_valid;
    logic [AW-1:0] upd_pc;
    logic          upd_is_jump;
    logic          upd_taken;
    logic [AW-1:0] upd_target;
    logic          upd_pred_taken;
    logic [AW-1:0] upd_pred_target;
    logic          mispredict;
    logic [AW-1:0] redirect_pc;
    logic          clear;
    logic [CW-1:0] cnt_lookup;
    logic [CW-1:0] cnt_hit;
    logic [CW-1:0] cnt_update;
    logic [CW-1:0] cnt_mispredict;

    branch_predictor #(
        .ENTRIES(N), .ADDR_W(AW), .CTR_W(2), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .lookup_en(lookup_en), .lookup_pc(lookup_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump),
        .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .clear(clear),
        .cnt_lookup(cnt_lookup), .cnt_hit(cnt_hit),
        .cnt_update(cnt_update), .cnt_mispredict(cnt_mispredict)
    );

    // ---------------- bookkeeping ----------------
    int errors = 0;
    int checks = 0;
    logic [PW-1:0] exp_q[$];

    // ---------------- reference model ----------------
    bit            m_valid  [N];
    logic [AW-1:0] m_tag    [N];
    logic [AW-1:0] m_target [N];
    bit            m_jump   [N];
    int            m_ctr    [N];
    logic [CW-1:0] e_lookup, e_hit, e_upd, e_mis;

    function automatic int m_idx(input logic [AW-1:0] pc);
        return int'((pc / 4) % N);
    endfunction

    function automatic logic [AW-1:0] m_tagof(input logic [AW-1:0] pc);
        return pc / (4 * N);
    endfunction

    function automatic bit m_hit(input logic [AW-1:0] pc);
        return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == m_tagof(pc));
    endfunction

    function automatic bit m_taken(input logic [AW-1:0] pc);
        return m_hit(pc) && (m_jump[m_idx(pc)] || m_ctr[m_idx(pc)] >= 2);
    endfunction

    function automatic logic [AW-1:0] m_pred_target(input logic [AW-1:0] pc);
        return m_taken(pc) ? m_target[m_idx(pc)] : pc + 32'd4;
    endfunction

    function automatic bit m_mis();
        if (!upd_valid) return 1'b0;
        if (upd_taken != upd_pred_taken) return 1'b1;
        return upd_taken && (upd_target != upd_pred_target);
    endfunction

    function automatic logic [AW-1:0] m_redirect();
        return upd_taken ? upd_target : upd_pc + 32'd4;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 0; m_tag[i] = '0; m_target[i] = '0; m_jump[i] = 0; m_ctr[i] = 0;
        end
        e_lookup = '0; e_hit = '0; e_upd = '0; e_mis = '0;
    endtask

    task automatic model_train();
        int i;
        i = m_idx(upd_pc);
        if (m_hit(upd_pc)) begin
            if (upd_is_jump) begin
                m_ctr[i] = 3; m_target[i] = upd_target; m_jump[i] = 1;
            end else if (upd_taken) begin
                m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
                m_target[i] = upd_target;
            end else begin
                m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
            end
        end else if (upd_taken) begin
            m_valid[i] = 1; m_tag[i] = m_tagof(upd_pc); m_target[i] = upd_target;
            m_jump[i] = upd_is_jump; m_ctr[i] = upd_is_jump ? 3 : 2;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_lookup(input bit en, input logic [AW-1:0] pc);
        lookup_en = en;
        lookup_pc = pc;
    endtask

    task automatic set_update(input bit v, input logic [AW-1:0] pc, input bit j, input bit t,
                              input logic [AW-1:0] tgt, input bit pt, input logic [AW-1:0] ptgt);
        upd_valid = v; upd_pc = pc; upd_is_jump = j; upd_taken = t;
        upd_target = tgt; upd_pred_taken = pt; upd_pred_target = ptgt;
    endtask

    task automatic idle_update();
        set_update(0, '0, 0, 0, '0, 0, '0);
    endtask

    // Advance one clock edge, applying the same inputs to the model first.
    task automatic tick();
        if (reset) begin
            if (lookup_en) e_lookup = e_lookup + 1;
            if (lookup_en && m_hit(lookup_pc)) e_hit = e_hit + 1;
            if (upd_valid) e_upd = e_upd + 1;
            if (m_mis()) e_mis = e_mis + 1;
            if (clear) begin
                for (int i = 0; i < N; i++) m_valid[i] = 0;
            end else if (upd_valid) begin
                model_train();
            end
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0;
        clear = 1'b0;
        set_lookup(0, '0);
        idle_update();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        set_lookup(1, 32'h40);
        #1;
        checks++;
        if (pred_hit !== 1'b0 || pred_taken !== 1'b0) begin
            errors++;
            $display("FAIL reset_pred: hit=%0b taken=%0b, want 0 0", pred_hit, pred_taken);
        end
        checks++;
        if (pred_target !== 32'h44) begin
            errors++;
            $display("FAIL reset_target: got %h want 00000044", pred_target);
        end
        checks++;
        if (cnt_lookup !== '0 || cnt_hit !== '0 || cnt_update !== '0 || cnt_mispredict !== '0) begin
            errors++;
            $display("FAIL reset_counters: %0d %0d %0d %0d want all 0",
                     cnt_lookup, cnt_hit, cnt_update, cnt_mispredict);
        end
        tick();
        checks++;
        if (cnt_lookup !== 32'd1 || cnt_hit !== 32'd0) begin
            errors++;
            $display("FAIL reset_first_lookup: cnt_lookup=%0d cnt_hit=%0d want 1 0", cnt_lookup, cnt_hit);
        end
    endtask

    task automatic test_allocate();
        set_lookup(0, '0);
        set_update(1, 32'h40, 0, 1, 32'h100, 0, 32'h44);
        #1;
        checks++;
        if (mispredict !== 1'b1 || redirect_pc !== 32'h100) begin
            errors++;
            $display("FAIL alloc_mispredict: mis=%0b redirect=%h want 1 00000100", mispredict, redirect_pc);
        end
        tick();
        idle_update();
        set_lookup(1, 32'h40);
        #1;
        checks++;
        if (pred_hit !== 1'b1 || pred_taken !== 1'b1 || pred_target !== 32'h100) begin
            errors++;
            $display("FAIL alloc_lookup: hit=%0b taken=%0b target=%h want 1 1 00000100",
                     pred_hit, pred_taken, pred_target);
        end
        checks++;
        if (cnt_mispredict !== 32'd1) begin
            errors++;
            $display("FAIL alloc_cnt_mis: got %0d want 1", cnt_mispredict);
        end
        tick();
    endtask

    task automatic test_counter();
        bit exp_nt [3];
        bit exp_t  [4];
        exp_nt = '{0, 0, 0};
        exp_t  = '{0, 1, 1, 1};
        for (int i = 0; i < 3; i++) begin
            set_update(1, 32'h40, 0, 0, 32'h0, 1, 32'h100);
            tick();
            idle_update();
            set_lookup(1, 32'h40);
            #1;
            checks++;
            if (pred_taken !== exp_nt[i] || pred_taken !== m_taken(32'h40) || pred_target !== 32'h44) begin
                errors++;
                $display("FAIL ctr_down[%0d]: taken=%0b target=%h want %0b 00000044",
                         i, pred_taken, pred_target, exp_nt[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            set_update(1, 32'h40, 0, 1, 32'h100, 0, 32'h44);
            tick();
            idle_update();
            set_lookup(1, 32'h40);
            #1;
            checks++;
            if (pred_taken !== exp_t[i] || pred_target !== (exp_t[i] ? 32'h100 : 32'h44)) begin
                errors++;
                $display("FAIL ctr_up[%0d]: taken=%0b target=%h want %0b", i, pred_taken, pred_target, exp_t[i]);
            end
        end
        set_update(1, 32'h40, 0, 0, 32'h0, 1, 32'h100);
        #1;
        checks++;
        if (mispredict !== 1'b1 || redirect_pc !== 32'h44) begin
            errors++;
            $display("FAIL ctr_nt_mis: mis=%0b redirect=%h want 1 00000044", mispredict, redirect_pc);
        end
        tick();
        idle_update();
    endtask

    task automatic test_alias();
        set_lookup(0, '0);
        set_update(1, 32'h80, 0, 1, 32'h200, 0, 32'h84);
        tick();
        idle_update();
        set_lookup(1, 32'h40);
        #1;
        checks++;
        if (pred_hit !== 1'b0 || pred_target !== 32'h44) begin
            errors++;
            $display("FAIL alias_evicted: hit=%0b target=%h want 0 00000044", pred_hit, pred_target);
        end
        set_lookup(1, 32'h80);
        #1;
        checks++;
        if (pred_hit !== 1'b1 || pred_taken !== 1'b1 || pred_target !== 32'h200) begin
            errors++;
            $display("FAIL alias_new: hit=%0b taken=%0b target=%h want 1 1 00000200",
                     pred_hit, pred_taken, pred_target);
        end
        tick();
        set_update(1, 32'hC0, 1, 1, 32'h300, 0, 32'hC4);
        tick();
        idle_update();
        set_lookup(1, 32'hC0);
        #1;
        checks++;
        if (pred_hit !== 1'b1 || pred_taken !== 1'b1 || pred_target !== 32'h300) begin
            errors++;
            $display("FAIL jal_alloc: hit=%0b taken=%0b target=%h want 1 1 00000300",
                     pred_hit, pred_taken, pred_target);
        end
        tick();
    endtask

    task automatic test_same_cycle();
        clear = 1'b1;
        set_lookup(0, '0);
        tick();
        clear = 1'b0;
        set_lookup(1, 32'h40);
        set_update(1, 32'h40, 0, 1, 32'h100, 0, 32'h44);
        #1;
        checks++;
        if (pred_hit !== 1'b0 || pred_target !== 32'h44) begin
            errors++;
            $display("FAIL same_cycle_before: hit=%0b target=%h want 0 00000044", pred_hit, pred_target);
        end
        tick();
        idle_update();
        #1;
        checks++;
        if (pred_hit !== 1'b1 || pred_target !== 32'h100) begin
            errors++;
            $display("FAIL same_cycle_after: hit=%0b target=%h want 1 00000100", pred_hit, pred_target);
        end
        clear = 1'b1;
        set_update(1, 32'h80, 0, 1, 32'h200, 0, 32'h84);
        tick();
        clear = 1'b0;
        idle_update();
        set_lookup(1, 32'h40);
        #1;
        checks++;
        if (pred_hit !== 1'b0) begin
            errors++;
            $display("FAIL clear_40: hit=%0b want 0", pred_hit);
        end
        set_lookup(1, 32'h80);
        #1;
        checks++;
        if (pred_hit !== 1'b0 || pred_target !== 32'h84) begin
            errors++;
            $display("FAIL clear_update_dropped: hit=%0b target=%h want 0 00000084", pred_hit, pred_target);
        end
        checks++;
        if (cnt_lookup !== e_lookup || cnt_hit !== e_hit || cnt_update !== e_upd || cnt_mispredict !== e_mis) begin
            errors++;
            $display("FAIL clear_counters: got %0d %0d %0d %0d want %0d %0d %0d %0d",
                     cnt_lookup, cnt_hit, cnt_update, cnt_mispredict, e_lookup, e_hit, e_upd, e_mis);
        end
        tick();
    endtask

    task automatic test_async_reset();
        set_update(1, 32'h40, 0, 1, 32'h100, 0, 32'h44);
        tick();
        set_update(1, 32'h40, 0, 1, 32'h100, 1, 32'h100);
        tick();
        idle_update();
        set_lookup(1, 32'h40);
        #1;
        checks++;
        if (pred_hit !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre: hit=%0b want 1", pred_hit);
        end
        #1;
        reset = 1'b0;
        #1;
        model_reset();
        checks++;
        if (pred_hit !== 1'b0 || pred_taken !== 1'b0 || pred_target !== 32'h44) begin
            errors++;
            $display("FAIL areset_pred: hit=%0b taken=%0b target=%h want 0 0 00000044",
                     pred_hit, pred_taken, pred_target);
        end
        checks++;
        if (cnt_lookup !== '0 || cnt_hit !== '0 || cnt_update !== '0 || cnt_mispredict !== '0) begin
            errors++;
            $display("FAIL areset_counters: %0d %0d %0d %0d want all 0",
                     cnt_lookup, cnt_hit, cnt_update, cnt_mispredict);
        end
        // Updates held during reset must not reach the table.
        set_update(1, 32'h40, 1, 1, 32'h900, 0, 32'h44);
        tick();
        tick();
        reset = 1'b1;
        idle_update();
        #1;
        checks++;
        if (pred_hit !== 1'b0 || cnt_update !== '0) begin
            errors++;
            $display("FAIL areset_held: hit=%0b cnt_update=%0d want 0 0", pred_hit, cnt_update);
        end
        set_update(1, 32'h40, 0, 1, 32'h100, 0, 32'h44);
        #1;
        checks++;
        if (mispredict !== 1'b1 || redirect_pc !== 32'h100) begin
            errors++;
            $display("FAIL areset_fresh_mis: mis=%0b redirect=%h want 1 00000100", mispredict, redirect_pc);
        end
        tick();
        // Fresh allocation is weakly taken: one not-taken drops it below taken.
        set_update(1, 32'h40, 0, 0, 32'h0, 1, 32'h100);
        tick();
        idle_update();
        #1;
        checks++;
        if (pred_hit !== 1'b1 || pred_taken !== 1'b0 || pred_target !== 32'h44) begin
            errors++;
            $display("FAIL areset_fresh_weak: hit=%0b taken=%0b target=%h want 1 0 00000044",
                     pred_hit, pred_taken, pred_target);
        end
        tick();
    endtask

    task automatic test_random();
        logic [AW-1:0] pc;
        logic [PW-1:0] exp_v;
        logic [PW-1:0] got_v;
        bit            j;
        for (int c = 0; c < 400; c++) begin
            set_lookup($urandom_range(0, 3) != 0,
                       (AW'($urandom_range(0, 3)) << 6) | (AW'($urandom_range(0, 15)) << 2));
            pc = (AW'($urandom_range(0, 3)) << 6) | (AW'($urandom_range(0, 15)) << 2);
            j  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) != 0) begin
                if ($urandom_range(0, 3) != 0)
                    set_update(1, pc, j, j ? 1'b1 : 1'($urandom_range(0, 1)),
                               AW'($urandom_range(0, 255)) << 2, m_taken(pc), m_pred_target(pc));
                else
                    set_update(1, pc, j, j ? 1'b1 : 1'($urandom_range(0, 1)),
                               AW'($urandom_range(0, 255)) << 2, 1'($urandom_range(0, 1)),
                               AW'($urandom_range(0, 255)) << 2);
            end else begin
                idle_update();
            end
            clear = ($urandom_range(0, 29) == 0);
            #1;
            exp_q.push_back({m_hit(lookup_pc), m_taken(lookup_pc), m_pred_target(lookup_pc),
                             m_mis(), m_redirect()});
            exp_v = exp_q.pop_front();
            got_v = {pred_hit, pred_taken, pred_target, mispredict, redirect_pc};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL rand_cycle[%0d]: got hit=%0b tk=%0b tgt=%h mis=%0b rd=%h want hit=%0b tk=%0b tgt=%h mis=%0b rd=%h",
                         c, got_v[PW-1], got_v[PW-2], got_v[PW-3 -: AW], got_v[AW], got_v[AW-1:0],
                         exp_v[PW-1], exp_v[PW-2], exp_v[PW-3 -: AW], exp_v[AW], exp_v[AW-1:0]);
            end
            tick();
            if (c % 50 == 49) begin
                checks++;
                if (cnt_lookup !== e_lookup || cnt_hit !== e_hit || cnt_update !== e_upd || cnt_mispredict !== e_mis) begin
                    errors++;
                    $display("FAIL rand_counters[%0d]: got %0d %0d %0d %0d want %0d %0d %0d %0d", c,
                             cnt_lookup, cnt_hit, cnt_update, cnt_mispredict, e_lookup, e_hit, e_upd, e_mis);
                end
            end
        end
        clear = 1'b0;
        idle_update();
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_allocate();
        test_counter();
        test_alias();
        test_same_cycle();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
